// File: rtl/ts_pkg.sv
// Shared transport-stream definitions for the CI transmit path:
// packet geometry, sync byte, FIFO word layout and framer states.
package ts_pkg;

   localparam int unsigned TS_PKT_LEN   = 188;
   localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

   typedef enum logic [1:0] {
      HUNT,
      WAIT_PKT,
      SEND,
      GAP
   } ts_state_e;

   // FIFO word: bit 8 flags the first byte of a packet, bits 7:0 carry data.
   typedef struct packed {
      logic       pkt_start;
      logic [7:0] data;
   } ts_word_t;

   function automatic logic ts_is_sync(input ts_word_t w);
      return w.pkt_start && (w.data == TS_SYNC_BYTE);
   endfunction

endpackage

// File: rtl/ts_ci_tx_framer.sv
// Packet-aligned CI transmit framer: waits for a whole buffered TS packet,
// bursts it onto MDI/MIVAL/MISTRT, re-hunts sync and enforces an idle gap.
module ts_ci_tx_framer
   import ts_pkg::*;
#(
   parameter int unsigned PKT_LEN    = TS_PKT_LEN,
   parameter int unsigned GAP_CYCLES = 4,
   parameter int unsigned USEDW_W    = 8
) (
   input  logic               clk_9,
   input  logic               reset,
   input  logic               enable,
   input  logic [8:0]         fifo_q,
   input  logic               fifo_rdempty,
   input  logic [USEDW_W-1:0] fifo_rdusedw,
   output logic               fifo_rdreq,
   output logic [7:0]         ci_mdi,
   output logic               ci_mival,
   output logic               ci_mistrt,
   output logic [23:0]        pkt_cnt,
   output logic [15:0]        err_cnt
);

   localparam int unsigned IDX_W    = $clog2(PKT_LEN);
   // The WAIT_PKT cycle after GAP also shows MIVAL low, so GAP dwells one
   // cycle less than the required idle run.
   localparam int unsigned GAP_HOLD = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 1;
   localparam int unsigned GAP_W    = (GAP_HOLD > 1) ? $clog2(GAP_HOLD) : 1;

   ts_state_e        r_state;
   logic [IDX_W-1:0] r_idx;
   logic [GAP_W-1:0] r_gap;
   logic [7:0]       r_mdi;
   logic             r_mival;
   logic             r_mistrt;
   logic [23:0]      r_pkt_cnt;
   logic [15:0]      r_err_cnt;

   ts_word_t         w_head;
   logic             w_head_sync;
   logic             w_trunc;
   logic             w_pkt_ready;
   logic             w_rdreq;
   logic [15:0]      w_err_next;

   assign w_head      = fifo_q;
   assign w_head_sync = ts_is_sync(w_head);
   assign w_trunc     = w_head.pkt_start && (r_idx != '0);
   assign w_pkt_ready = 32'(fifo_rdusedw) >= PKT_LEN;
   assign w_err_next  = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 16'd1;

   always_comb begin
      w_rdreq = 1'b0;
      if (reset && !fifo_rdempty) begin
         case (r_state)
            HUNT:    w_rdreq = !w_head_sync;
            SEND:    w_rdreq = !w_trunc;
            default: w_rdreq = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_9) begin
      if (!reset) begin
         r_state   <= HUNT;
         r_idx     <= '0;
         r_gap     <= '0;
         r_mdi     <= '0;
         r_mival   <= 1'b0;
         r_mistrt  <= 1'b0;
         r_pkt_cnt <= '0;
         r_err_cnt <= '0;
      end else begin
         r_mival  <= 1'b0;
         r_mistrt <= 1'b0;
         unique case (r_state)
            HUNT: begin
               if (!fifo_rdempty) begin
                  if (w_head_sync)
                     r_state <= WAIT_PKT;
                  else if (w_head.pkt_start)
                     r_err_cnt <= w_err_next;
               end
            end
            WAIT_PKT: begin
               if (fifo_rdempty || !w_head_sync) begin
                  r_state <= HUNT;
               end else if (enable && w_pkt_ready) begin
                  r_state <= SEND;
                  r_idx   <= '0;
               end
            end
            SEND: begin
               // Empty head stalls with MIVAL low; a new start mid-packet truncates.
               if (!fifo_rdempty) begin
                  if (w_trunc) begin
                     r_err_cnt <= w_err_next;
                     r_idx     <= '0;
                     r_state   <= WAIT_PKT;
                  end else begin
                     r_mdi    <= w_head.data;
                     r_mival  <= 1'b1;
                     r_mistrt <= (r_idx == '0);
                     if (r_idx == '0)
                        r_pkt_cnt <= r_pkt_cnt + 24'd1;
                     if (r_idx == IDX_W'(PKT_LEN - 1)) begin
                        r_idx   <= '0;
                        r_gap   <= '0;
                        r_state <= GAP;
                     end else begin
                        r_idx <= r_idx + IDX_W'(1);
                     end
                  end
               end
            end
            GAP: begin
               if (r_gap == GAP_W'(GAP_HOLD - 1)) begin
                  r_gap   <= '0;
                  r_state <= WAIT_PKT;
               end else begin
                  r_gap <= r_gap + GAP_W'(1);
               end
            end
            default: r_state <= HUNT;
         endcase
      end
   end

   assign fifo_rdreq = w_rdreq;
   assign ci_mdi     = r_mdi;
   assign ci_mival   = r_mival;
   assign ci_mistrt  = r_mistrt;
   assign pkt_cnt    = r_pkt_cnt;
   assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_ts_ci_tx_framer.sv
// Directed bench for ts_ci_tx_framer: show-ahead FIFO model feeding the DUT,
// bus bytes scored against an expected queue filled as packets are loaded.
module tb_ts_ci_tx_framer;
   import ts_pkg::*;

   localparam int unsigned PKT_LEN = 188;

   logic        clk_9  = 1'b0;
   logic        reset  = 1'b0;
   logic        enable = 1'b0;
   logic [8:0]  fifo_q;
   logic        fifo_rdempty;
   logic [7:0]  fifo_rdusedw;
   logic        fifo_rdreq;
   logic [7:0]  ci_mdi;
   logic        ci_mival;
   logic        ci_mistrt;
   logic [23:0] pkt_cnt;
   logic [15:0] err_cnt;

   logic [8:0]  head_r      = '0;
   logic        qempty_r    = 1'b1;
   logic [7:0]  used_r      = '0;
   logic        force_empty = 1'b0;
   logic        ovr_en      = 1'b0;
   logic [7:0]  ovr_val     = '0;

   logic [8:0]  fq[$];
   logic [8:0]  exp_q[$];
   int unsigned runs[$];
   int unsigned lows[$];

   int          checks     = 0;
   int          errors     = 0;
   int          pop_cnt    = 0;
   int          start_pops = 0;
   int          base       = 0;
   int unsigned hi_run     = 0;
   int unsigned lo_run     = 0;

   assign fifo_q       = head_r;
   assign fifo_rdempty = qempty_r | force_empty;
   assign fifo_rdusedw = ovr_en ? ovr_val : used_r;

   ts_ci_tx_framer #(
      .PKT_LEN   (PKT_LEN),
      .GAP_CYCLES(4),
      .USEDW_W   (8)
   ) dut (
      .clk_9       (clk_9),
      .reset       (reset),
      .enable      (enable),
      .fifo_q      (fifo_q),
      .fifo_rdempty(fifo_rdempty),
      .fifo_rdusedw(fifo_rdusedw),
      .fifo_rdreq  (fifo_rdreq),
      .ci_mdi      (ci_mdi),
      .ci_mival    (ci_mival),
      .ci_mistrt   (ci_mistrt),
      .pkt_cnt     (pkt_cnt),
      .err_cnt     (err_cnt)
   );

   always #5 clk_9 = ~clk_9;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // FIFO model: pop on the edge that sees rdreq, present the new head at negedge.
   always @(posedge clk_9) begin
      if (fifo_rdreq) begin
         chk("rdreq_when_empty", 32'(fifo_rdempty), 32'd0);
         if (fq.size() != 0) void'(fq.pop_front());
         pop_cnt++;
      end
   end

   always @(negedge clk_9) begin
      head_r   = (fq.size() != 0) ? fq[0] : 9'h000;
      qempty_r = (fq.size() == 0);
      used_r   = (fq.size() > 255) ? 8'd255 : 8'(fq.size());
   end

   // Bus monitor: score every valid byte, log high and low run lengths.
   always @(negedge clk_9) begin
      if (ci_mival) begin
         if (lo_run != 0) lows.push_back(lo_run);
         lo_run = 0;
         hi_run++;
         if (ci_mistrt) start_pops = pop_cnt;
         if (exp_q.size() == 0)
            chk("bus_unexpected", 32'(ci_mival), 32'd0);
         else
            chk("bus_byte", 32'({ci_mistrt, ci_mdi}), 32'(exp_q.pop_front()));
      end else begin
         if (hi_run != 0) runs.push_back(hi_run);
         hi_run = 0;
         lo_run++;
      end
   end

   task automatic tick();
      @(posedge clk_9);
      #1;
   endtask

   task automatic push_pkt(input int n_words, input int n_exp);
      logic [7:0] d;
      for (int i = 0; i < n_words; i++) begin
         d = (i == 0) ? TS_SYNC_BYTE : 8'($urandom);
         fq.push_back({i == 0, d});
         if (i < n_exp) exp_q.push_back({i == 0, d});
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      runs.delete();
      lows.delete();
      base = pop_cnt;
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         tick();
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      repeat (4) tick();
   endtask

   task automatic wait_pops(input string tag, input int target, input int limit);
      int n = 0;
      while (pop_cnt < target && n < limit) begin
         tick();
         n++;
      end
      chk(tag, 32'(pop_cnt), 32'(target));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with a word waiting that must not be popped.
      fq.push_back(9'h0AA);
      repeat (3) tick();
      chk("rst_mival", 32'(ci_mival), 32'd0);
      chk("rst_mistrt", 32'(ci_mistrt), 32'd0);
      chk("rst_mdi", 32'(ci_mdi), 32'd0);
      chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);

      // Two back-to-back packets.
      enable = 1'b1;
      runs.delete();
      lows.delete();
      push_pkt(PKT_LEN, PKT_LEN);
      push_pkt(PKT_LEN, PKT_LEN);
      reset = 1'b1;
      drain(2000);
      chk("b2b_runs", 32'(runs.size()), 32'd2);
      chk("b2b_run0", runs[0], 32'd188);
      chk("b2b_run1", runs[1], 32'd188);
      chk("b2b_lows", 32'(lows.size()), 32'd2);
      chk("b2b_gap", lows[1], 32'd4);
      chk("b2b_pkt_cnt", 32'(pkt_cnt), 32'd2);
      chk("b2b_err_cnt", 32'(err_cnt), 32'd0);

      // Garbage, one bad start, then a valid packet.
      pulse_reset();
      for (int i = 0; i < 50; i++) fq.push_back({1'b0, 8'($urandom)});
      fq.push_back({1'b1, 8'h12});
      push_pkt(PKT_LEN, PKT_LEN);
      drain(1000);
      // 51 discarded words plus byte 0 have been popped when MISTRT shows.
      chk("hunt_pops", 32'(start_pops - base), 32'd52);
      chk("hunt_err_cnt", 32'(err_cnt), 32'd1);
      chk("hunt_pkt_cnt", 32'(pkt_cnt), 32'd1);
      chk("hunt_runs", 32'(runs.size()), 32'd1);
      chk("hunt_run0", runs[0], 32'd188);

      // Packet truncated after 100 bytes by the next sync word.
      pulse_reset();
      push_pkt(100, 100);
      push_pkt(PKT_LEN, PKT_LEN);
      drain(1000);
      chk("trunc_runs", 32'(runs.size()), 32'd2);
      chk("trunc_run0", runs[0], 32'd100);
      chk("trunc_run1", runs[1], 32'd188);
      chk("trunc_err_cnt", 32'(err_cnt), 32'd1);
      chk("trunc_pkt_cnt", 32'(pkt_cnt), 32'd2);

      // One word short of a packet holds off; underrun at byte 60 stalls.
      pulse_reset();
      ovr_en  = 1'b1;
      ovr_val = 8'd187;
      push_pkt(PKT_LEN, PKT_LEN);
      repeat (20) tick();
      chk("short_pops", 32'(pop_cnt - base), 32'd0);
      chk("short_mival", 32'(ci_mival), 32'd0);
      chk("short_pkt_cnt", 32'(pkt_cnt), 32'd0);
      ovr_en = 1'b0;
      wait_pops("stall_reach60", base + 60, 300);
      force_empty = 1'b1;
      repeat (3) tick();
      force_empty = 1'b0;
      drain(1000);
      chk("stall_runs", 32'(runs.size()), 32'd2);
      chk("stall_run0", runs[0], 32'd60);
      chk("stall_run1", runs[1], 32'd128);
      chk("stall_lows", 32'(lows.size()), 32'd2);
      chk("stall_low1", lows[1], 32'd3);
      chk("stall_pkt_cnt", 32'(pkt_cnt), 32'd1);
      chk("stall_err_cnt", 32'(err_cnt), 32'd0);

      // Reset at byte 90 aborts; the tail is hunted away silently.
      pulse_reset();
      push_pkt(PKT_LEN, 90);
      wait_pops("rst90_reach", base + 90, 400);
      reset = 1'b0;
      tick();
      chk("rst90_mival", 32'(ci_mival), 32'd0);
      chk("rst90_pkt_cnt", 32'(pkt_cnt), 32'd0);
      tick();
      reset = 1'b1;
      repeat (150) tick();
      chk("rst90_pops", 32'(pop_cnt - base), 32'd188);
      chk("rst90_fifo", 32'(fq.size()), 32'd0);
      chk("rst90_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst90_pkt_cnt_after", 32'(pkt_cnt), 32'd0);
      chk("rst90_exp_left", 32'(exp_q.size()), 32'd0);

      // enable dropped mid-packet: current packet finishes, next waits.
      pulse_reset();
      push_pkt(PKT_LEN, PKT_LEN);
      push_pkt(PKT_LEN, 0);
      wait_pops("en_reach50", base + 50, 400);
      enable = 1'b0;
      for (int n = 0; n < 400 && runs.size() == 0; n++) tick();
      chk("en_first_done", 32'(runs.size()), 32'd1);
      repeat (20) tick();
      chk("en_hold_pkt_cnt", 32'(pkt_cnt), 32'd1);
      chk("en_hold_mival", 32'(ci_mival), 32'd0);
      chk("en_hold_fifo", 32'(fq.size()), 32'd188);
      foreach (fq[i]) exp_q.push_back(fq[i]);
      enable = 1'b1;
      drain(1000);
      chk("en_pkt_cnt", 32'(pkt_cnt), 32'd2);
      chk("en_runs", 32'(runs.size()), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ts_ci_tx_framer.md
# ts_ci_tx_framer

Packet-aligned transmit framer between the CI input FIFO read port and the CI bus pins, in the clk_9 domain. It replaces free-running FIFO draining. It waits until one whole transport packet is buffered, then bursts it onto CI_MDI/MIVAL/MISTRT with MISTRT exactly on the 0x47 sync byte. It re-hunts sync after truncated or misaligned packets, and it enforces a minimum idle gap between packets for the CAM.

## Interface
- PKT_LEN, 188: bytes per TS packet.
- GAP_CYCLES, 4: minimum MIVAL-low clk_9 cycles between packets (≥1).
- USEDW_W, 8: width of FIFO read-side used-word count.
- clk_9  in  1  CI bus clock, also the FIFO read clock.
- reset  in  1  reset, synchronous, active-low.
- enable  in  1  permits starting new packets.
- fifo_q  in  9  show-ahead head word: [8] pkt_start, [7:0] data.
- fifo_rdempty  in  1  FIFO empty.
- fifo_rdusedw  in  USEDW_W  words buffered.
- fifo_rdreq  out  1  pops the head word (combinational, never asserted when empty).
- ci_mdi  out  8  CI input data, registered.
- ci_mival  out  1  CI data valid, registered.
- ci_mistrt  out  1  CI packet start, registered.
- pkt_cnt  out  24  packets started on the bus, wraps.
- err_cnt  out  16  sync/truncation errors, saturating at 0xFFFF.

## Operation
- FIFO is show-ahead. A word is consumed in the cycle fifo_rdreq=1 and is presented on the bus the next cycle.
- States: HUNT, WAIT_PKT, SEND, GAP.
- HUNT: pop and discard every head word until the head has pkt_start=1 and data=0x47. Do not pop that word; go to WAIT_PKT. Each discarded word that had pkt_start=1 but data≠0x47 increments err_cnt.
- WAIT_PKT:
  - If the head word is not a valid start (pkt_start=0 or data≠0x47), go to HUNT.
  - Otherwise, when enable=1 and fifo_rdusedw ≥ PKT_LEN, go to SEND with byte index 0.
- SEND: pop one word per cycle while not empty; byte index counts 0..PKT_LEN-1.
  - Index 0 drives ci_mistrt=1 on the bus cycle.
  - After popping index PKT_LEN-1, go to GAP.
  - Truncation: the head has pkt_start=1 at index>0. Do not pop it; increment err_cnt; go to WAIT_PKT. The partial packet has already been sent and is not recalled.
  - Underrun: fifo_rdempty mid-packet. Stall with no pop and ci_mival=0 that cycle, and resume on data. Underrun is not counted as an error.
- GAP: hold for GAP_CYCLES cycles with ci_mival=0, then go to WAIT_PKT.
- enable is sampled only in WAIT_PKT. Deasserting enable during SEND lets the current packet finish.
- pkt_cnt increments on each cycle ci_mistrt=1 is driven.

## Timing
- Reset (reset=0 at a clk_9 edge): state HUNT, index 0, gap counter 0, ci_mdi=0, ci_mival=0, ci_mistrt=0, pkt_cnt=0, err_cnt=0. fifo_rdreq=0 while reset=0.
- Reset mid-SEND aborts the packet immediately. ci_mival falls on the first reset edge. The FIFO content is not flushed; HUNT resynchronises after reset.
- Latency: WAIT_PKT→SEND transition at edge t; first pop in cycle t..t+1; first bus byte with MIVAL=MISTRT=1 registered at the edge after the pop.
- No stalls: PKT_LEN consecutive MIVAL=1 cycles, MISTRT high for exactly the first.
- Inter-packet MIVAL-low run is ≥ GAP_CYCLES, plus any WAIT_PKT wait.
- ci_mdi holds its last value while ci_mival=0.
- Simultaneous truncation and empty cannot occur, because empty means no head word; empty takes the stall path.
- Counter arithmetic: pkt_cnt is modulo 2^24. err_cnt does not wrap.

## Structure
- Shared package ts_pkg holds:
  - TS_PKT_LEN=188 and TS_SYNC_BYTE=8'h47;
  - the state encoding (HUNT, WAIT_PKT, SEND, GAP);
  - the FIFO word layout (bit 8 = pkt_start).
- The block has no sub-module; it is a single FSM plus index, gap and two statistics counters.
- It instantiates beside ts_ci_fifo's read port and drives the CI bus output pins directly.

## Test plan
- Two back-to-back 188-byte packets preloaded, enable=1:
  - 188 MIVAL cycles with MISTRT on the 0x47 byte;
  - 4 idle cycles, then 188 more;
  - pkt_cnt=2, err_cnt=0.
- 50 garbage words (pkt_start=0), then one word with pkt_start=1 and data 0x12, then a valid packet: 51 words popped, nothing on the bus, err_cnt=1; the packet is then sent intact.
- Packet truncated after 100 bytes by a new pkt_start/0x47 word:
  - 100 bus bytes, then MIVAL low and err_cnt=1;
  - the following packet starts with MISTRT=1, pkt_cnt=2.
- fifo_rdusedw=187 with a valid head: no pop and MIVAL stays 0; at usedw=188 transmission starts. Forcing empty at byte 60 for 3 cycles gives 3 MIVAL-low cycles, then bytes 60..187 follow.
- reset=0 at byte 90: at the next edge MIVAL=0 and pkt_cnt=0. After release the block hunts and the remaining 98 words are discarded without error (pkt_start=0).
- enable=0 mid-packet: the packet completes; no new MISTRT until enable=1.
